// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard and pipeline control for a 5-stage in-order pipeline.
//
// Decides, every cycle, which pipeline registers hold (stall) and which are
// cleared to bubbles (flush), and whether the PC must be redirected.  A small
// FSM tracks multi-cycle data-memory waits and the one-cycle bubble that
// follows an exception entry or exception return.
//
// Ports
//   clk             single clock, all state updates on posedge
//   rst             asynchronous, active-low reset
//   if_req_stall    fetch side not ready (icache miss)
//   mem_req_stall   data memory not ready for the MEM-stage access
//   ex_is_load      EX-stage instruction is a load
//   ex_rw_en        EX-stage instruction writes a register
//   ex_rw_addr      EX-stage destination register
//   id_rs1_en/rs2_en, id_rs1/rs2   ID-stage source operands
//   br_taken        EX-stage branch/jump needs a redirect
//   excp_valid      MEM-stage exception
//   ertn_valid      MEM-stage exception return
//   stall, flush    per-stage controls: bit0 PC, bit1 IF_ID, bit2 ID_EX,
//                   bit3 EX_MEM, bit4 MEM_WB
//   redirect_valid  PC redirect request
//   redirect_sel    01 branch, 10 exception entry, 11 ertn
//   stall_cnt       saturating count of cycles with stall[0]=1
//
// CNT_RST_VAL is the value stall_cnt takes while reset is asserted; it is
// zero in normal use and only changed to observe saturation quickly.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] CNT_RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_stall,
    input  logic        mem_req_stall,
    input  logic        ex_is_load,
    input  logic        ex_rw_en,
    input  logic [4:0]  ex_rw_addr,
    input  logic        id_rs1_en,
    input  logic        id_rs2_en,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        br_taken,
    input  logic        excp_valid,
    input  logic        ertn_valid,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redirect_valid,
    output logic [1:0]  redirect_sel,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_EXCP     = 2'd2;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_EXCP   = 2'b10;
    localparam logic [1:0] SEL_ERTN   = 2'b11;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_is_load && ex_rw_en && (ex_rw_addr != 5'd0) &&
                      ((id_rs1_en && (id_rs1 == ex_rw_addr)) ||
                       (id_rs2_en && (id_rs2 == ex_rw_addr)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers latches.
        stall          = 5'b00000;
        flush          = 5'b00000;
        redirect_valid = 1'b0;
        redirect_sel   = SEL_NONE;
        state_nxt      = S_RUN;

        if (!rst) begin
            // Reset clears every stage without waiting for a clock edge.
            flush = 5'b11111;
        end else if (state == S_EXCP) begin
            // One bubble cycle after exception entry/return; inputs ignored.
            flush = 5'b11110;
        end else if ((state == S_MEM_WAIT) && mem_req_stall) begin
            // Memory still busy: freeze everything up to EX_MEM and keep
            // bubbling MEM_WB; no other event may disturb the frozen stages.
            stall     = 5'b01111;
            flush     = 5'b10000;
            state_nxt = S_MEM_WAIT;
        end else if (excp_valid) begin
            flush          = 5'b11110;
            redirect_valid = 1'b1;
            redirect_sel   = SEL_EXCP;
            state_nxt      = S_EXCP;
        end else if (ertn_valid) begin
            flush          = 5'b11110;
            redirect_valid = 1'b1;
            redirect_sel   = SEL_ERTN;
            state_nxt      = S_EXCP;
        end else if (mem_req_stall) begin
            stall     = 5'b01111;
            flush     = 5'b10000;
            state_nxt = S_MEM_WAIT;
        end else if (br_taken) begin
            // The branch squashes the ID instruction, so any load-use hazard
            // it had disappears with it.
            flush          = 5'b00110;
            redirect_valid = 1'b1;
            redirect_sel   = SEL_BRANCH;
        end else if (load_use) begin
            stall = 5'b00011;
            flush = 5'b00100;
        end else if (if_req_stall) begin
            stall = 5'b00001;
            flush = 5'b00010;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for all registered state so every
        // flop samples the values from before the edge.
        if (!rst) begin
            state     <= S_RUN;
            stall_cnt <= CNT_RST_VAL;
        end else begin
            state <= state_nxt;
            if (stall[0] && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// A reference model tracks two facts about the pipeline (is a memory wait in
// progress, is this the bubble after an exception) plus the stall count, and
// derives the expected controls from the priority rules.  Directed sequences
// cover the documented scenarios, then random traffic is checked against the
// same model.  A second instance with a near-maximum count reset value shows
// saturation of stall_cnt.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    typedef struct packed {
        logic       ifs;
        logic       mems;
        logic       ld;
        logic       rwen;
        logic [4:0] rwa;
        logic       rs1en;
        logic       rs2en;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       ex;
        logic       er;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_stall = 1'b0;
    logic        mem_req_stall = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_rw_en = 1'b0;
    logic [4:0]  ex_rw_addr = 5'd0;
    logic        id_rs1_en = 1'b0;
    logic        id_rs2_en = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        br_taken = 1'b0;
    logic        excp_valid = 1'b0;
    logic        ertn_valid = 1'b0;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] stall_cnt;

    logic        sat_ifs = 1'b0;
    logic [4:0]  sat_stall;
    logic [4:0]  sat_flush;
    logic        sat_rv;
    logic [1:0]  sat_sel;
    logic [31:0] sat_cnt;

    localparam logic [31:0] SAT_START = 32'hFFFF_FFFC;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit     m_mem_wait;
    bit     m_bubble;
    longint m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_stall   (if_req_stall),
        .mem_req_stall  (mem_req_stall),
        .ex_is_load     (ex_is_load),
        .ex_rw_en       (ex_rw_en),
        .ex_rw_addr     (ex_rw_addr),
        .id_rs1_en      (id_rs1_en),
        .id_rs2_en      (id_rs2_en),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .br_taken       (br_taken),
        .excp_valid     (excp_valid),
        .ertn_valid     (ertn_valid),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .stall_cnt      (stall_cnt)
    );

    pipe_ctrl #(.CNT_RST_VAL(SAT_START)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .if_req_stall   (sat_ifs),
        .mem_req_stall  (1'b0),
        .ex_is_load     (1'b0),
        .ex_rw_en       (1'b0),
        .ex_rw_addr     (5'd0),
        .id_rs1_en      (1'b0),
        .id_rs2_en      (1'b0),
        .id_rs1         (5'd0),
        .id_rs2         (5'd0),
        .br_taken       (1'b0),
        .excp_valid     (1'b0),
        .ertn_valid     (1'b0),
        .stall          (sat_stall),
        .flush          (sat_flush),
        .redirect_valid (sat_rv),
        .redirect_sel   (sat_sel),
        .stall_cnt      (sat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] e_stall,
                                 input logic [4:0] e_flush, input logic e_rv,
                                 input logic [1:0] e_sel, input logic [31:0] e_cnt);
        check({tag, ".stall"}, {27'd0, stall}, {27'd0, e_stall});
        check({tag, ".flush"}, {27'd0, flush}, {27'd0, e_flush});
        check({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, e_rv});
        check({tag, ".sel"},   {30'd0, redirect_sel}, {30'd0, e_sel});
        check({tag, ".cnt"},   stall_cnt, e_cnt);
    endtask

    // One clock cycle: apply stimulus after the falling edge, check the
    // combinational response, then advance the model past the next rise.
    task automatic cycle(input stim_t s, input string tag);
        logic [4:0] e_stall;
        logic [4:0] e_flush;
        logic       e_rv;
        logic [1:0] e_sel;
        bit         hazard;

        @(negedge clk);
        if_req_stall  = s.ifs;
        mem_req_stall = s.mems;
        ex_is_load    = s.ld;
        ex_rw_en      = s.rwen;
        ex_rw_addr    = s.rwa;
        id_rs1_en     = s.rs1en;
        id_rs2_en     = s.rs2en;
        id_rs1        = s.rs1;
        id_rs2        = s.rs2;
        br_taken      = s.br;
        excp_valid    = s.ex;
        ertn_valid    = s.er;
        #1;

        hazard = s.ld && s.rwen && (s.rwa != 0) &&
                 ((s.rs1en && s.rs1 == s.rwa) || (s.rs2en && s.rs2 == s.rwa));
        e_stall = 5'b00000;
        e_flush = 5'b00000;
        e_rv    = 1'b0;
        e_sel   = 2'b00;

        if (m_bubble) begin
            e_flush    = 5'b11110;
            m_bubble   = 0;
            m_mem_wait = 0;
        end else if (m_mem_wait && s.mems) begin
            e_stall = 5'b01111;
            e_flush = 5'b10000;
        end else begin
            m_mem_wait = 0;
            if (s.ex || s.er) begin
                e_flush  = 5'b11110;
                e_rv     = 1'b1;
                e_sel    = s.ex ? 2'b10 : 2'b11;
                m_bubble = 1;
            end else if (s.mems) begin
                e_stall    = 5'b01111;
                e_flush    = 5'b10000;
                m_mem_wait = 1;
            end else if (s.br) begin
                e_flush = 5'b00110;
                e_rv    = 1'b1;
                e_sel   = 2'b01;
            end else if (hazard) begin
                e_stall = 5'b00011;
                e_flush = 5'b00100;
            end else if (s.ifs) begin
                e_stall = 5'b00001;
                e_flush = 5'b00010;
            end
        end

        check_outputs(tag, e_stall, e_flush, e_rv, e_sel, m_cnt[31:0]);
        if (e_stall[0] && m_cnt < 64'h0000_0000_FFFF_FFFF)
            m_cnt++;
    endtask

    // Assert reset away from any clock edge, confirm the reset response
    // immediately and across an edge, then release away from an edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b0;
        m_mem_wait = 0;
        m_bubble   = 0;
        m_cnt      = 0;
        #1;
        check_outputs({tag, ".async"}, 5'b00000, 5'b11111, 1'b0, 2'b00, 32'd0);
        check({tag, ".sat_rst"}, sat_cnt, SAT_START);
        @(negedge clk);
        #1;
        check_outputs({tag, ".held"}, 5'b00000, 5'b11111, 1'b0, 2'b00, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        stim_t s;
        stim_t z;
        z = '0;

        // Reset state.
        do_reset("reset");
        cycle(z, "idle");

        // Load-use on rs2, then the same load writing x0.
        do_reset("lu_rst");
        s = z; s.ld = 1; s.rwen = 1; s.rwa = 5'd5; s.rs2en = 1; s.rs2 = 5'd5;
        cycle(s, "load_use");
        s.rwa = 5'd0; s.rs2 = 5'd0;
        cycle(s, "load_x0");
        check("load_use.cnt1", stall_cnt, 32'd1);
        s = z; s.ld = 1; s.rwen = 1; s.rwa = 5'd9; s.rs1en = 1; s.rs1 = 5'd9; s.br = 1;
        cycle(s, "br_over_lu");

        // Memory wait with a branch pending throughout.
        do_reset("mw_rst");
        s = z; s.mems = 1; s.br = 1;
        cycle(s, "mw1");
        s.ex = 1;
        cycle(s, "mw2_excp_ign");
        s.ex = 0;
        cycle(s, "mw3");
        s.mems = 0;
        cycle(s, "mw_release_br");
        cycle(z, "mw_after");
        check("mw.cnt3", stall_cnt, 32'd3);

        // Exception beats everything, followed by exactly one bubble.
        do_reset("ex_rst");
        s = z; s.ex = 1; s.br = 1; s.ifs = 1;
        cycle(s, "excp");
        cycle(s, "excp_bubble");
        cycle(z, "excp_run");

        // ertn then an exception during the bubble.
        s = z; s.er = 1;
        cycle(s, "ertn");
        s = z; s.ex = 1;
        cycle(s, "ertn_bubble");
        cycle(z, "ertn_run");

        // Reset in the middle of a memory wait.
        s = z; s.mems = 1;
        cycle(s, "mw_pre1");
        cycle(s, "mw_pre2");
        do_reset("mw_async");
        cycle(z, "mw_post_rst");

        // Reset in the middle of the exception bubble.
        s = z; s.ex = 1;
        cycle(s, "bub_pre");
        do_reset("bub_async");
        s = z; s.ifs = 1;
        cycle(s, "bub_post_rst");

        // Random traffic; small register range to make hazards common.
        for (int i = 0; i < 600; i++) begin
            s.ex    = ($urandom_range(15) == 0);
            s.er    = ($urandom_range(15) == 0);
            s.mems  = ($urandom_range(3) == 0);
            s.br    = ($urandom_range(4) == 0);
            s.ifs   = ($urandom_range(3) == 0);
            s.ld    = $urandom_range(1);
            s.rwen  = $urandom_range(1);
            s.rwa   = 5'($urandom_range(3));
            s.rs1en = $urandom_range(1);
            s.rs2en = $urandom_range(1);
            s.rs1   = 5'($urandom_range(3));
            s.rs2   = 5'($urandom_range(3));
            cycle(s, $sformatf("rnd%0d", i));
        end

        // Saturation on the preset instance via sustained fetch stalls.
        do_reset("sat_rst");
        @(negedge clk);
        sat_ifs = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("sat.near", sat_cnt, 32'hFFFF_FFFE);
        repeat (6) @(posedge clk);
        #1 check("sat.hold", sat_cnt, 32'hFFFF_FFFF);
        sat_ifs = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: if_req_stall  input  1  fetch side not ready (icache miss).
REQ-004 SHALL have port: mem_req_stall  input  1  data memory not ready for the MEM-stage access.
REQ-005 SHALL have ports: ex_is_load  input  1; ex_rw_en  input  1; ex_rw_addr  input  5 -- EX-stage load and its destination register.
REQ-006 SHALL have ports: id_rs1_en, id_rs2_en  input  1; id_rs1, id_rs2  input  5 -- ID-stage source operands.
REQ-007 SHALL have port: br_taken  input  1  EX-stage branch/jump resolved as mispredicted/taken.
REQ-008 SHALL have ports: excp_valid, ertn_valid  input  1  MEM-stage exception / exception-return.
REQ-009 SHALL have ports: stall  output  5; flush  output  5 -- bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB.
REQ-010 SHALL have ports: redirect_valid  output  1; redirect_sel  output  2 -- 01 branch, 10 exception entry, 11 ertn.
REQ-011 SHALL have port: stall_cnt  output  32  number of cycles with stall[0]=1.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, EXCP; stall/flush/redirect are combinational from state and inputs; state and stall_cnt registered.
REQ-013 Default (no condition active): stall=00000, flush=00000, redirect_valid=0, redirect_sel=00.
REQ-014 Priority in RUN, highest first: excp_valid, ertn_valid, mem_req_stall, br_taken, load-use, if_req_stall; only the highest active condition drives outputs.
REQ-015 RUN, excp_valid: flush=11110, stall=00000, redirect_valid=1, redirect_sel=10; next state EXCP.
REQ-016 RUN, ertn_valid (no excp_valid): same as REQ-015 but redirect_sel=11.
REQ-017 EXCP: flush=11110, stall=00000, redirect_valid=0, all inputs ignored; next state RUN unconditionally (exactly one bubble cycle).
REQ-018 RUN, mem_req_stall: stall=01111, flush=10000; next state MEM_WAIT.
REQ-019 MEM_WAIT with mem_req_stall=1: stall=01111, flush=10000; excp/ertn/br_taken/load-use ignored; stays MEM_WAIT.
REQ-020 MEM_WAIT with mem_req_stall=0: outputs evaluated as in RUN for this cycle (REQ-014 priority); next state per RUN rules.
REQ-021 br_taken: flush=00110, stall=00000, redirect_valid=1, redirect_sel=01; single-cycle pulse.
REQ-022 Load-use = ex_is_load & ex_rw_en & ex_rw_addr!=0 & ((id_rs1_en & id_rs1==ex_rw_addr) | (id_rs2_en & id_rs2==ex_rw_addr)); response: stall=00011, flush=00100.
REQ-023 br_taken with load-use: branch wins (ID instruction squashed, no stall).
REQ-024 if_req_stall alone: stall=00001, flush=00010.
REQ-025 stall_cnt SHALL increment by 1 on each posedge where stall[0]=1; saturates at 0xFFFFFFFF.

Reset
REQ-026 While rst=0: state=RUN, stall_cnt=0, stall=00000, flush=11111, redirect_valid=0, redirect_sel=00, regardless of clock.
REQ-027 Reset asserted mid-MEM_WAIT or mid-EXCP SHALL return to RUN immediately; first cycle after release behaves as RUN.

Verification
REQ-028 Load-use: ex_is_load=1, ex_rw_en=1, ex_rw_addr=5, id_rs2_en=1, id_rs2=5 -> stall=00011, flush=00100, stall_cnt +1; with ex_rw_addr=0 -> stall=00000.
REQ-029 mem_req_stall high 3 cycles from RUN, br_taken=1 throughout -> 3 cycles stall=01111/flush=10000, no redirect; 4th cycle (mem_req_stall=0) redirect_valid=1, sel=01, flush=00110; stall_cnt=3.
REQ-030 excp_valid=1 with br_taken=1 and if_req_stall=1 -> flush=11110, redirect sel=10; next cycle EXCP flush=11110, redirect_valid=0; then RUN.
REQ-031 ertn_valid=1 followed next cycle by excp_valid=1 -> cycle 1 redirect sel=11; cycle 2 (EXCP) excp ignored, no redirect.
REQ-032 rst=0 asynchronously during MEM_WAIT -> outputs immediately flush=11111, stall=00000, stall_cnt=0; after release with no inputs, defaults per REQ-013.
REQ-033 stall_cnt preloaded near max via sustained if_req_stall -> holds at 0xFFFFFFFF, no wrap.
